// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one APB bus among NUM_REQ command sources.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_rr_arbiter #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [1:0]                       PSEL,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic                             PENABLE,
  input  logic                             PREADY,
  input  logic [DATA_WIDTH-1:0]            PRDATA
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_rr_arbiter: unsupported parameters");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         pick;
  logic [GW-1:0]         cand;
  logic                  found;
  logic                  tmo;
  int                    idx;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  logic [1:0]            psel_d;
  logic                  penable_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic                  pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  // search requesters starting just after the last one served
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = idx[GW-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign sel_addr  = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];

  // accept pulse to the winner while idle
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[pick] = 1'b1;
  end

  // state register
  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // current grant and round-robin pointer
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
    end else begin
      if (state == IDLE && found) grant <= pick;
      if (state == RESP) last_grant <= grant;
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tcnt;
  logic          err_d;

  // count ACCESS cycles spent waiting on PREADY
  always_ff @(posedge PCLK) begin
    if (PRESET)                          tcnt <= '0;
    else if (state == SETUP)             tcnt <= '0;
    else if (state == ACCESS && !PREADY) tcnt <= tcnt + 1'b1;
  end

  assign tmo = (state == ACCESS) &&
               (tcnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (found) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // next values of the registered bus and response outputs
  always_comb begin
    psel_d      = PSEL;
    penable_d   = PENABLE;
    paddr_d     = PADDR;
    pwrite_d    = PWRITE;
    pwdata_d    = PWDATA;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata;
`ifdef APB_TIMEOUT_EN
    err_d       = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          psel_d   = sel_addr[ADDR_WIDTH-1] ? 2'b10 : 2'b01;
          penable_d = 1'b0;
          paddr_d  = sel_addr;
          pwrite_d = req_write[pick];
          if (req_write[pick]) pwdata_d = sel_wdata;
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (PREADY) begin
          psel_d             = 2'b00;
          penable_d          = 1'b0;
          rsp_valid_d[grant] = 1'b1;
          if (!PWRITE) rsp_rdata_d = PRDATA;
        end else if (tmo) begin
          psel_d             = 2'b00;
          penable_d          = 1'b0;
          rsp_valid_d[grant] = 1'b1;
          rsp_rdata_d        = '0;
`ifdef APB_TIMEOUT_EN
          err_d              = 1'b1;
`endif
        end
      end
      RESP: begin
        psel_d    = 2'b00;
        penable_d = 1'b0;
      end
      default: ;
    endcase
  end

  // output registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PADDR     <= paddr_d;
      PWRITE    <= pwrite_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  // error flag accompanies a timed-out response
  always_ff @(posedge PCLK) begin
    if (PRESET) rsp_err <= 1'b0;
    else        rsp_err <= err_d;
  end
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter.
// Timeout scenario built only when APB_TIMEOUT_EN is defined.
module tb_apb_rr_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int N  = 4;

  logic            PCLK = 1'b0;
  logic            PRESET = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic [AW-1:0]   PADDR;
  logic [1:0]      PSEL;
  logic            PWRITE;
  logic [DW-1:0]   PWDATA;
  logic            PENABLE;
  logic            PREADY = 1'b0;
  logic [DW-1:0]   PRDATA = '0;

  int total = 0;
  int bad   = 0;

  apb_rr_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_REQ(N), .TIMEOUT_CYCLES(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PENABLE(PENABLE),
    .PREADY(PREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  task tick;
    @(posedge PCLK);
    #1;
  endtask

  task set_cmd(input int i, input logic w,
               input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]         = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task test_reset;
    PRESET = 1'b1;
    tick;
    tick;
    total++;
    if (PSEL !== 2'b00 || PENABLE !== 1'b0) begin
      bad++;
      $display("FAIL reset_bus got psel=%b en=%b want psel=00 en=0",
               PSEL, PENABLE);
    end
    total++;
    if (PADDR !== '0 || PWDATA !== '0 || PWRITE !== 1'b0) begin
      bad++;
      $display("FAIL reset_cmd got a=%h d=%h w=%b want 0 0 0",
               PADDR, PWDATA, PWRITE);
    end
    total++;
    if (rsp_valid !== '0 || rsp_rdata !== '0 || rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_rsp got v=%b d=%h e=%b want 0 0 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    PRESET = 1'b0;
    tick;
    total++;
    if (req_ready !== '0) begin
      bad++;
      $display("FAIL reset_ready got=%b want=0000", req_ready);
    end
  endtask

  task test_single_write;
    set_cmd(2, 1'b1, 10'h005, 16'hBEEF);
    req_valid = 4'b0100;
    PREADY = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL wr_ready got=%b want=0100", req_ready);
    end
    tick;
    req_valid = '0;
    set_cmd(2, 1'b0, 10'h3AA, 16'h1111);
    total++;
    if (PSEL !== 2'b01 || PENABLE !== 1'b0 || PWRITE !== 1'b1) begin
      bad++;
      $display("FAIL wr_setup got psel=%b en=%b w=%b want 01 0 1",
               PSEL, PENABLE, PWRITE);
    end
    total++;
    if (PADDR !== 10'h005 || PWDATA !== 16'hBEEF) begin
      bad++;
      $display("FAIL wr_setup_data got a=%h d=%h want 005 beef",
               PADDR, PWDATA);
    end
    tick;
    total++;
    if (PENABLE !== 1'b1 || PSEL !== 2'b01 || PADDR !== 10'h005 ||
        PWDATA !== 16'hBEEF) begin
      bad++;
      $display("FAIL wr_access got en=%b psel=%b a=%h d=%h",
               PENABLE, PSEL, PADDR, PWDATA);
    end
    tick;
    total++;
    if (rsp_valid !== 4'b0100 || rsp_err !== 1'b0 ||
        PSEL !== 2'b00 || PENABLE !== 1'b0) begin
      bad++;
      $display("FAIL wr_resp got v=%b e=%b psel=%b en=%b want 0100 0 00 0",
               rsp_valid, rsp_err, PSEL, PENABLE);
    end
    tick;
    total++;
    if (rsp_valid !== '0) begin
      bad++;
      $display("FAIL wr_idle got v=%b want=0000", rsp_valid);
    end
    PREADY = 1'b0;
  endtask

  task test_read_wait;
    int en_cnt;
    logic got;
    set_cmd(0, 1'b0, 10'h3FF, 16'h0000);
    req_valid = 4'b0001;
    PRDATA = 16'h1234;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rd_ready got=%b want=0001", req_ready);
    end
    tick;
    req_valid = '0;
    total++;
    if (PSEL !== 2'b10 || PWRITE !== 1'b0 || PADDR !== 10'h3FF) begin
      bad++;
      $display("FAIL rd_setup got psel=%b w=%b a=%h want 10 0 3ff",
               PSEL, PWRITE, PADDR);
    end
    total++;
    if (PWDATA !== 16'hBEEF) begin
      bad++;
      $display("FAIL rd_pwdata_hold got=%h want=beef", PWDATA);
    end
    en_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (PENABLE === 1'b1) en_cnt++;
      PREADY = (en_cnt == 4);
      tick;
      if (rsp_valid !== '0) got = 1'b1;
    end
    PREADY = 1'b0;
    total++;
    if (en_cnt != 4) begin
      bad++;
      $display("FAIL rd_enable_cycles got=%0d want=4", en_cnt);
    end
    total++;
    if (rsp_valid !== 4'b0001 || rsp_rdata !== 16'h1234 ||
        rsp_err !== 1'b0) begin
      bad++;
      $display("FAIL rd_resp got v=%b d=%h e=%b want 0001 1234 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    tick;
  endtask

  task test_round_robin;
    int n;
    logic [N-1:0] exp;
    PRESET = 1'b1;
    tick;
    PRESET = 1'b0;
    for (int i = 0; i < N; i++) set_cmd(i, 1'b1, 10'(10'h040 + i), 16'(i));
    PREADY = 1'b1;
    req_valid = '1;
    #1;
    for (int t = 0; t < 5; t++) begin
      exp = 4'b0001 << (t % 4);
      n = 0;
      while (req_ready === '0 && n < 8) begin
        tick;
        n++;
      end
      total++;
      if (req_ready !== exp) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b want=%b", t, req_ready, exp);
      end
      tick;
      if (t == 4) req_valid = '0;
      total++;
      if (PADDR !== 10'(10'h040 + (t % 4))) begin
        bad++;
        $display("FAIL rr_paddr%0d got=%h want=%h", t, PADDR,
                 10'(10'h040 + (t % 4)));
      end
    end
    tick;
    tick;
    tick;
    PREADY = 1'b0;
  endtask

  task test_late_arrival;
    set_cmd(3, 1'b0, 10'h200, 16'h0000);
    req_valid = 4'b1000;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL late_ready3 got=%b want=1000", req_ready);
    end
    tick;
    req_valid = '0;
    tick;
    set_cmd(1, 1'b0, 10'h010, 16'h0000);
    req_valid = 4'b0010;
    #1;
    total++;
    if (req_ready !== '0 || PENABLE !== 1'b1) begin
      bad++;
      $display("FAIL late_wait got rdy=%b en=%b want 0000 1",
               req_ready, PENABLE);
    end
    tick;
    PREADY = 1'b1;
    PRDATA = 16'hCAFE;
    tick;
    PREADY = 1'b0;
    PRDATA = 16'h0BAD;
    #1;
    total++;
    if (rsp_valid !== 4'b1000 || rsp_rdata !== 16'hCAFE ||
        req_ready !== '0) begin
      bad++;
      $display("FAIL late_resp3 got v=%b d=%h rdy=%b want 1000 cafe 0000",
               rsp_valid, rsp_rdata, req_ready);
    end
    tick;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL late_ready1 got=%b want=0010", req_ready);
    end
    tick;
    req_valid = '0;
    total++;
    if (PADDR !== 10'h010 || PSEL !== 2'b01) begin
      bad++;
      $display("FAIL late_setup1 got a=%h psel=%b want 010 01",
               PADDR, PSEL);
    end
    PREADY = 1'b1;
    tick;
    tick;
    total++;
    if (rsp_valid !== 4'b0010 || rsp_rdata !== 16'h0BAD) begin
      bad++;
      $display("FAIL late_resp1 got v=%b d=%h want 0010 0bad",
               rsp_valid, rsp_rdata);
    end
    PREADY = 1'b0;
    tick;
  endtask

  task test_reset_mid_access;
    set_cmd(2, 1'b0, 10'h020, 16'h0000);
    req_valid = 4'b0100;
    tick;
    req_valid = '0;
    tick;
    total++;
    if (PENABLE !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre_access got en=%b want=1", PENABLE);
    end
    PRESET = 1'b1;
    tick;
    PRESET = 1'b0;
    total++;
    if (PSEL !== 2'b00 || PENABLE !== 1'b0 || rsp_valid !== '0) begin
      bad++;
      $display("FAIL rst_mid got psel=%b en=%b v=%b want 00 0 0000",
               PSEL, PENABLE, rsp_valid);
    end
    tick;
    total++;
    if (rsp_valid !== '0) begin
      bad++;
      $display("FAIL rst_no_rsp got v=%b want=0000", rsp_valid);
    end
    set_cmd(0, 1'b1, 10'h001, 16'h0A0A);
    req_valid = 4'b0101;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rst_first_grant got=%b want=0001", req_ready);
    end
    tick;
    req_valid = '0;
    PREADY = 1'b1;
    tick;
    tick;
    total++;
    if (rsp_valid !== 4'b0001) begin
      bad++;
      $display("FAIL rst_after_rsp got v=%b want=0001", rsp_valid);
    end
    PREADY = 1'b0;
    tick;
  endtask

`ifdef APB_TIMEOUT_EN
  task test_timeout;
    int en_cnt;
    logic got;
    for (int r = 0; r < 2; r++) begin
      set_cmd(1, 1'b0, 10'h100, 16'h0000);
      PRDATA = 16'h5A5A;
      req_valid = 4'b0010;
      tick;
      req_valid = '0;
      en_cnt = 0;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
        if (PENABLE === 1'b1) en_cnt++;
        PREADY = (r == 1) && (en_cnt == 16);
        tick;
        if (rsp_valid !== '0) got = 1'b1;
      end
      PREADY = 1'b0;
      total++;
      if (en_cnt != 16) begin
        bad++;
        $display("FAIL tmo_cycles%0d got=%0d want=16", r, en_cnt);
      end
      total++;
      if (rsp_valid !== 4'b0010 || rsp_err !== (r == 0) ||
          rsp_rdata !== ((r == 0) ? 16'h0000 : 16'h5A5A)) begin
        bad++;
        $display("FAIL tmo_resp%0d got v=%b e=%b d=%h", r,
                 rsp_valid, rsp_err, rsp_rdata);
      end
      total++;
      if (PSEL !== 2'b00 || PENABLE !== 1'b0) begin
        bad++;
        $display("FAIL tmo_bus%0d got psel=%b en=%b want 00 0", r,
                 PSEL, PENABLE);
      end
      tick;
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single_write;
    test_read_wait;
    test_round_robin;
    test_late_arrival;
    test_reset_mid_access;
`ifdef APB_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
